// File: rtl/spi_pwm_config_pkg.sv
// Shared constants for the SPI configuration port: frame size, register map
// addresses and the frame-capture FSM state encoding.
package spi_cfg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

endpackage

// File: rtl/spi_pwm_config_if.sv
// SPI pad bundle (mode 0, write-only): the controller drives all three lines.
interface spi_pwm_config_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_pwm_config_bit_sync.sv
// Multi-flop synchronizer for one asynchronous pad signal; the reset value is
// selectable so idle levels (e.g. nCS high) survive reset without false edges.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the pad value through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{rst_val_i}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_pwm_config.sv
// SPI mode-0 write-only configuration port. Captures 16-bit frames
// (R/W, 7-bit address, 8-bit data) and commits complete, valid writes into
// the output-enable / PWM register bank.
module spi_pwm_config #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_pwm_config_if.slave        spi,
  output logic [7:0]             en_reg_out_7_0,
  output logic [7:0]             en_reg_out_15_8,
  output logic [7:0]             en_reg_pwm_7_0,
  output logic [7:0]             en_reg_pwm_15_8,
  output logic [7:0]             pwm_duty_cycle,
  output logic                   cfg_wr_pulse
);
  import spi_cfg_pkg::*;

  localparam logic [4:0] CNT_FULL   = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT    = 5'(FRAME_BITS + 1);
  localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

  logic sclk_s, copi_s, ncs_s;
  logic sclk_prev_q, ncs_prev_q;
  logic sclk_rise, ncs_fall;

  state_e      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wr_en;

  logic [7:0] en_out_lo_q, en_out_hi_q, en_pwm_lo_q, en_pwm_hi_q, duty_q;
  logic       wr_pulse_q;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .rst_val_i(1'b0), .d_i(spi.sclk), .q_o(sclk_s)
  );
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .rst_val_i(1'b0), .d_i(spi.copi), .q_o(copi_s)
  );
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .rst_val_i(1'b1), .d_i(spi.ncs), .q_o(ncs_s)
  );

  // Previous synchronized levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  // FSM state, shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: nCS high always ends the frame, and takes priority over
  // a coincident SCLK rise so that edge is never counted.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (ncs_s) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[14:0], copi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        wr_en   = (cnt_q == CNT_FULL) && shreg_q[15] && (shreg_q[14:8] < NUM_REGS_A);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register bank and write strobe; exactly one register per committed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_lo_q <= '0;
      en_out_hi_q <= '0;
      en_pwm_lo_q <= '0;
      en_pwm_hi_q <= '0;
      duty_q      <= '0;
      wr_pulse_q  <= 1'b0;
    end else begin
      wr_pulse_q <= wr_en;
      if (wr_en) begin
        case (shreg_q[14:8])
          ADDR_EN_OUT_LO: en_out_lo_q <= shreg_q[7:0];
          ADDR_EN_OUT_HI: en_out_hi_q <= shreg_q[7:0];
          ADDR_EN_PWM_LO: en_pwm_lo_q <= shreg_q[7:0];
          ADDR_EN_PWM_HI: en_pwm_hi_q <= shreg_q[7:0];
          ADDR_DUTY:      duty_q      <= shreg_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = en_out_lo_q;
  assign en_reg_out_15_8 = en_out_hi_q;
  assign en_reg_pwm_7_0  = en_pwm_lo_q;
  assign en_reg_pwm_15_8 = en_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign cfg_wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_spi_pwm_config.sv
// Directed bench for spi_pwm_config: SPI frames driven at SCLK = clk/8,
// register bank compared against hand-derived values after every frame.
module tb_spi_pwm_config;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic cfg_wr_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pulse_base;
  logic [7:0] m [5];

  spi_pwm_config_if spi ();

  spi_pwm_config #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi.slave),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .cfg_wr_pulse(cfg_wr_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cfg_wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_reg(input int i);
    case (i)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic check_bank(input string tag);
    for (int i = 0; i < 5; i++) chk($sformatf("%s_r%0d", tag, i), 16'(get_reg(i)), 16'(m[i]));
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit is_valid(input logic [16:0] d, input int n);
    return (n == 16) && d[15] && (d[14:8] < 7'd5);
  endfunction

  task automatic model(input logic [16:0] d, input int n);
    if (is_valid(d, n)) m[int'(d[14:8])] = d[7:0];
  endtask

  // Drives n bits of d (MSB first), leaves nCS high at the end.
  task automatic send_frame(input logic [16:0] d, input int n);
    spi.ncs = 1'b0;
    wait_clk(4);
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = d[i];
      wait_clk(4);
      spi.sclk = 1'b1;
      wait_clk(4);
      spi.sclk = 1'b0;
    end
    wait_clk(4);
    spi.ncs = 1'b1;
  endtask

  task automatic frame_check(input string tag, input logic [16:0] d, input int n);
    pulse_base = pulse_cnt;
    send_frame(d, n);
    wait_clk(8);
    model(d, n);
    chk({tag, "_pulses"}, 16'(pulse_cnt - pulse_base), is_valid(d, n) ? 16'd1 : 16'd0);
    check_bank(tag);
  endtask

  initial begin
    logic [16:0] d;
    int n;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;

    // Reset state
    wait_clk(3);
    check_bank("reset");
    chk("reset_pulse", 16'(cfg_wr_pulse), 16'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // First write with commit-latency check (SYNC_STAGES+2 edges after nCS rise)
    pulse_base = pulse_cnt;
    send_frame(17'h080F0, 16);
    repeat (3) @(posedge clk);
    #1 chk("lat_early", 16'(en_reg_out_7_0), 16'h00);
    chk("lat_early_pulse", 16'(cfg_wr_pulse), 16'd0);
    @(posedge clk);
    #1 chk("lat_commit", 16'(en_reg_out_7_0), 16'hF0);
    chk("lat_pulse_hi", 16'(cfg_wr_pulse), 16'd1);
    @(posedge clk);
    #1 chk("lat_pulse_lo", 16'(cfg_wr_pulse), 16'd0);
    m[0] = 8'hF0;
    wait_clk(4);
    chk("w80F0_pulses", 16'(pulse_cnt - pulse_base), 16'd1);
    check_bank("w80F0");

    frame_check("w8480", 17'h08480, 16);
    chk("duty_80", 16'(pwm_duty_cycle), 16'h80);

    // Invalid address and read frame
    frame_check("badaddr", 17'h08A55, 16);
    frame_check("read", 17'h00055, 16);

    // Short and long frames, then a valid one
    frame_check("short15", 17'h040E6, 15);
    frame_check("long17", 17'h1039B, 17);
    frame_check("w81AB", 17'h081AB, 16);
    chk("out_hi_AB", 16'(en_reg_out_15_8), 16'hAB);

    // SCLK activity while nCS is high
    pulse_base = pulse_cnt;
    for (int i = 0; i < 12; i++) begin
      spi.copi = 1'($urandom_range(0, 1));
      spi.sclk = ~spi.sclk;
      wait_clk(4);
    end
    spi.sclk = 1'b0;
    wait_clk(8);
    chk("idle_sclk_pulses", 16'(pulse_cnt - pulse_base), 16'd0);
    check_bank("idle_sclk");

    // Back-to-back frames at the minimum nCS gap
    pulse_base = pulse_cnt;
    send_frame(17'h082FF, 16);
    wait_clk(4);
    send_frame(17'h08301, 16);
    wait_clk(8);
    model(17'h082FF, 16);
    model(17'h08301, 16);
    chk("b2b_pulses", 16'(pulse_cnt - pulse_base), 16'd2);
    chk("b2b_pwm_lo", 16'(en_reg_pwm_7_0), 16'hFF);
    chk("b2b_pwm_hi", 16'(en_reg_pwm_15_8), 16'h01);
    check_bank("b2b");

    // Random mix of valid and invalid frames
    for (int k = 0; k < 24; k++) begin
      d = 17'($urandom);
      case ($urandom_range(0, 3))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      if (n == 16) begin
        d[15]   = ($urandom_range(0, 3) != 0);
        d[14:8] = 7'($urandom_range(0, 7));
      end
      frame_check($sformatf("rnd%0d", k), d, n);
    end

    // Reset asserted mid-frame
    spi.ncs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 5; i++) begin
      spi.copi = 1'b1;
      wait_clk(4);
      spi.sclk = 1'b1;
      wait_clk(4);
      spi.sclk = 1'b0;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    wait_clk(1);
    check_bank("midrst");
    chk("midrst_pulse", 16'(cfg_wr_pulse), 16'd0);
    spi.ncs = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(8);
    check_bank("post_rst");
    frame_check("w8233", 17'h08233, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
